// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the serial frame receiver.
package serial_pkg;

  // Receiver state: hunting for the sync word, or deserialising a frame.
  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } rx_state_t;

  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_SYNC_W      = 8;
  localparam int unsigned DEF_FRAME_WORDS = 4;
  localparam logic [7:0]  DEF_SYNC_WORD   = 8'hA5;

  // Counter width able to index 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rx_hold_reg.sv
// One-entry valid/ready holding register for completed payload words.
// A word offered while the entry is occupied and not being drained in the
// same cycle is dropped and raises a sticky overflow flag.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   load, load_data completed word offered by the deserialiser
//   out_ready       consumer accept
//   out_data        held word, stable while out_valid is high
//   out_valid       entry occupied
//   overflow        sticky drop indicator, cleared only by reset
module rx_hold_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              overflow
);

  logic accept_c;

  assign accept_c = out_valid & out_ready;

  // A drain and a load in the same cycle chain back-to-back without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (load) begin
      if (!out_valid || accept_c) begin
        out_data  <= load_data;
        out_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (accept_c) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync word in a qualified bit stream,
// then deserialises FRAME_WORDS words MSB-first into a valid/ready port.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   din          serial bit, sampled only while din_valid is high
//   din_valid    bit qualifier
//   out_data     deserialised word
//   out_valid    word available
//   out_ready    consumer accept
//   locked       high from sync match until the last payload bit of a frame
//   frame_done   one-cycle pulse after the final word of a frame
//   overflow     sticky: a word was dropped because the holding register was full
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int unsigned             DATA_W      = DEF_DATA_W,
  parameter int unsigned             SYNC_W      = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0]       SYNC_WORD   = SYNC_W'(DEF_SYNC_WORD),
  parameter int unsigned             FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  input  logic              din_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              locked,
  output logic              frame_done,
  output logic              overflow
);

  localparam int unsigned BIT_CW  = cnt_w(DATA_W);
  localparam int unsigned WORD_CW = cnt_w(FRAME_WORDS);
  localparam int unsigned SEEN_W  = cnt_w(SYNC_W + 1);

  rx_state_t          state;
  // Shift registers keep only the older bits; the current din completes the window.
  logic [SYNC_W-2:0]  sync_sr;
  logic [DATA_W-2:0]  data_sr;
  logic [SEEN_W-1:0]  bits_seen;
  logic [BIT_CW-1:0]  bit_cnt;
  logic [WORD_CW-1:0] word_cnt;

  logic [SYNC_W-1:0]  sync_next_c;
  logic [DATA_W-1:0]  word_next_c;
  logic               sync_hit_c;
  logic               word_done_c;
  logic               last_word_c;

  // Match and completion decode, including the bit arriving this cycle.
  always_comb begin
    sync_next_c = {sync_sr, din};
    word_next_c = {data_sr, din};
    // bits_seen guard stops the reset-zero history from forming a match.
    sync_hit_c  = (state == HUNT) && din_valid && (sync_next_c == SYNC_WORD) &&
                  (bits_seen >= SEEN_W'(SYNC_W - 1));
    word_done_c = (state == PAYLOAD) && din_valid && (bit_cnt == BIT_CW'(DATA_W - 1));
    last_word_c = (word_cnt == WORD_CW'(FRAME_WORDS - 1));
  end

  // Frame FSM, shift registers and counters; nothing advances without din_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      sync_sr    <= '0;
      data_sr    <= '0;
      bits_seen  <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            sync_sr <= sync_next_c[SYNC_W-2:0];
            if (bits_seen != SEEN_W'(SYNC_W)) begin
              bits_seen <= bits_seen + SEEN_W'(1);
            end
            if (sync_hit_c) begin
              state    <= PAYLOAD;
              locked   <= 1'b1;
              bit_cnt  <= '0;
              word_cnt <= '0;
            end
          end
          PAYLOAD: begin
            data_sr <= word_next_c[DATA_W-2:0];
            if (word_done_c) begin
              bit_cnt <= '0;
              if (last_word_c) begin
                // Frame ends even if this word was dropped; hunt restarts from a clean window.
                word_cnt   <= '0;
                state      <= HUNT;
                locked     <= 1'b0;
                frame_done <= 1'b1;
                sync_sr    <= '0;
                bits_seen  <= '0;
              end else begin
                word_cnt <= word_cnt + WORD_CW'(1);
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_CW'(1);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  rx_hold_reg #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (word_done_c),
    .load_data (word_next_c),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx with hand-computed expectations.
module tb_serial_frame_rx;

  logic       clk;
  logic       reset;
  logic       din;
  logic       din_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       locked;
  logic       frame_done;
  logic       overflow;

  int unsigned checks;
  int unsigned errors;
  logic        seen_lock;

  serial_frame_rx dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .locked     (locked),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    din_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive one qualified bit; with gap, follow it by an unqualified garbage cycle.
  task automatic send_bit(input logic b, input bit gap);
    @(negedge clk);
    seen_lock = seen_lock | locked;
    din       = b;
    din_valid = 1'b1;
    if (gap) begin
      @(negedge clk);
      din_valid = 1'b0;
      din       = ~b;
    end
  endtask

  task automatic send_msbs(input logic [7:0] v, input int n, input bit gap);
    for (int i = 0; i < n; i++) send_bit(v[7-i], gap);
  endtask

  // Land just after the edge that captures the most recently driven bit.
  task automatic post();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] t4_words [4];

  initial begin
    checks    = 0;
    errors    = 0;
    seen_lock = 1'b0;
    reset     = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    out_ready = 1'b0;
    t4_words  = '{8'h11, 8'h22, 8'h33, 8'h44};

    // 1: reset state, then a run of ones must not lock
    do_reset();
    check("rst out_data",   32'(out_data),   32'h0);
    check("rst out_valid",  32'(out_valid),  32'h0);
    check("rst locked",     32'(locked),     32'h0);
    check("rst frame_done", 32'(frame_done), 32'h0);
    check("rst overflow",   32'(overflow),   32'h0);
    out_ready = 1'b1;
    seen_lock = 1'b0;
    for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b0);
    post();
    check("t1 locked",    32'(locked | seen_lock), 32'h0);
    check("t1 out_valid", 32'(out_valid),          32'h0);
    check("t1 overflow",  32'(overflow),           32'h0);

    // 2: clean frame, consumer always ready
    do_reset();
    out_ready = 1'b1;
    send_msbs(8'hA5, 8, 1'b0);
    post();
    check("t2 lock", 32'(locked), 32'h1);
    send_msbs(8'h3C, 8, 1'b0);
    post();
    check("t2 w0 valid", 32'(out_valid), 32'h1);
    check("t2 w0 data",  32'(out_data),  32'h3C);
    send_msbs(8'hC3, 8, 1'b0);
    post();
    check("t2 w1 data",  32'(out_data),  32'hC3);
    check("t2 w1 valid", 32'(out_valid), 32'h1);
    send_msbs(8'hFF, 8, 1'b0);
    post();
    check("t2 w2 data",   32'(out_data),   32'hFF);
    check("t2 mid locked", 32'(locked),    32'h1);
    check("t2 mid done",  32'(frame_done), 32'h0);
    send_msbs(8'h00, 8, 1'b0);
    post();
    check("t2 w3 data",   32'(out_data),   32'h00);
    check("t2 w3 valid",  32'(out_valid),  32'h1);
    check("t2 done",      32'(frame_done), 32'h1);
    check("t2 unlock",    32'(locked),     32'h0);
    @(negedge clk);
    din_valid = 1'b0;
    post();
    check("t2 done pulse", 32'(frame_done), 32'h0);
    check("t2 drained",    32'(out_valid),  32'h0);
    check("t2 overflow",   32'(overflow),   32'h0);

    // 3: alternating 0101... never forms the sync word
    do_reset();
    seen_lock = 1'b0;
    for (int i = 0; i < 64; i++) send_bit(1'(i & 1), 1'b0);
    post();
    check("t3 locked",    32'(locked | seen_lock), 32'h0);
    check("t3 out_valid", 32'(out_valid),          32'h0);

    // 4: prefix 1,0,1 then frame, din_valid toggling every cycle
    do_reset();
    out_ready = 1'b1;
    seen_lock = 1'b0;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    send_msbs(8'hA5, 7, 1'b1);
    check("t4 early lock", 32'(locked | seen_lock), 32'h0);
    send_bit(1'b1, 1'b1);
    check("t4 lock", 32'(locked), 32'h1);
    for (int w = 0; w < 4; w++) begin
      send_msbs(t4_words[w], 8, 1'b1);
      check("t4 valid", 32'(out_valid), 32'h1);
      check("t4 data",  32'(out_data),  32'(t4_words[w]));
    end
    check("t4 done",   32'(frame_done), 32'h1);
    check("t4 unlock", 32'(locked),     32'h0);

    // 5: consumer stalled; later words drop, overflow sticks until reset
    do_reset();
    out_ready = 1'b0;
    send_msbs(8'hA5, 8, 1'b0);
    send_msbs(8'h3C, 8, 1'b0);
    post();
    check("t5 w0 valid", 32'(out_valid), 32'h1);
    check("t5 w0 data",  32'(out_data),  32'h3C);
    check("t5 no ovf",   32'(overflow),  32'h0);
    send_msbs(8'hC3, 8, 1'b0);
    post();
    check("t5 hold data", 32'(out_data),  32'h3C);
    check("t5 ovf",       32'(overflow),  32'h1);
    send_msbs(8'hFF, 8, 1'b0);
    send_msbs(8'h00, 8, 1'b0);
    post();
    check("t5 dropped done", 32'(frame_done), 32'h1);
    check("t5 unlock",       32'(locked),     32'h0);
    check("t5 still 3C",     32'(out_data),   32'h3C);
    @(negedge clk);
    din_valid = 1'b0;
    out_ready = 1'b1;
    post();
    check("t5 drained",    32'(out_valid), 32'h0);
    check("t5 ovf sticky", 32'(overflow),  32'h1);
    post();
    check("t5 ovf sticky2", 32'(overflow), 32'h1);
    do_reset();
    check("t5 ovf cleared", 32'(overflow), 32'h0);

    // 6: drain in the completion cycle avoids overflow; reset mid-word, then relock
    do_reset();
    out_ready = 1'b0;
    send_msbs(8'hA5, 8, 1'b0);
    send_msbs(8'h3C, 8, 1'b0);
    post();
    check("t6 w0 data", 32'(out_data), 32'h3C);
    send_msbs(8'hC3, 7, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    din       = 1'b1;
    din_valid = 1'b1;
    post();
    out_ready = 1'b0;
    check("t6 w1 valid", 32'(out_valid), 32'h1);
    check("t6 w1 data",  32'(out_data),  32'hC3);
    check("t6 no ovf",   32'(overflow),  32'h0);
    send_msbs(8'hFF, 4, 1'b0);
    @(negedge clk);
    reset     = 1'b1;
    din_valid = 1'b0;
    post();
    check("t6 rst valid",  32'(out_valid),  32'h0);
    check("t6 rst data",   32'(out_data),   32'h0);
    check("t6 rst locked", 32'(locked),     32'h0);
    check("t6 rst done",   32'(frame_done), 32'h0);
    check("t6 rst ovf",    32'(overflow),   32'h0);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    send_msbs(8'hA5, 8, 1'b0);
    post();
    check("t6 relock", 32'(locked), 32'h1);
    send_msbs(8'h5A, 8, 1'b0);
    post();
    check("t6 relock valid", 32'(out_valid), 32'h1);
    check("t6 relock data",  32'(out_data),  32'h5A);
    @(negedge clk);
    din_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
